imem_hex_loader: RTL
====================

Name: imem_hex_loader

Overview:
- Parses a byte stream of ASCII hex text in the instruction-image format (one 32-bit word per 8 hex digits, whitespace separated).
- Writes each assembled word into instruction memory at consecutive word addresses.
- Sits between a character source (bench stimulus or UART RX) and the IM write port; the CPU is held off until `done` asserts.
- This is the reading end of the text dump the team's logging blocks write.

Parameters:
- ADDR_W, 10, IM word-address width (1024 words).
- BASE_ADDR, 0, word address of the first write after `start`.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; begins a load (ignored unless in IDLE, DONE or ERR).
- in_valid  in  1  in_char is valid this cycle.
- in_ready  out  1  loader accepts in_char this cycle.
- in_char  in  8  ASCII character.
- in_last  in  1  marks the final character of the stream; qualified by in_valid && in_ready.
- im_we  out  1  IM write strobe, one cycle per word.
- im_addr  out  ADDR_W  IM word address.
- im_wdata  out  32  assembled word.
- busy  out  1  high in LOAD.
- done  out  1  high in DONE.
- err  out  1  high in ERR.
- word_count  out  ADDR_W+1  words written in the current or last load.

Behaviour:
- Reset (async, active-low): state=IDLE; in_ready=0, im_we=0, im_addr=BASE_ADDR, im_wdata=0, busy=0, done=0, err=0, word_count=0, digit counter=0, shift register=0.
- States: IDLE, LOAD, DONE, ERR.
  - IDLE/DONE/ERR + start -> LOAD. On entry: clear word_count, digit counter, done and err; next address := BASE_ADDR.
  - in_ready = (state==LOAD). No backpressure from IM; a transfer occurs when in_valid && in_ready.
- Character classes in LOAD:
  - Hex digit 0-9, A-F, a-f: shift[31:0] := {shift[27:0], nibble}; digit_cnt++.
  - Whitespace (0x20, 0x09, 0x0A, 0x0D): legal only when digit_cnt is 0 or 8; otherwise -> ERR.
  - Any other character -> ERR.
- Word write:
  - The 8th digit accepted at cycle t produces im_we=1 at t+1, with im_addr = current address and im_wdata = the assembled word. The address then increments and word_count++.
  - digit_cnt resets to 0, so a 9th consecutive digit starts a new word. Back-to-back words with no separator are legal.
- Overflow: a word completing when word_count == 2^ADDR_W -> ERR, no write. Address never wraps.
- in_last:
  - Processed as its own character first, including any write it triggers.
  - Then: digit_cnt==0 -> DONE. Partial word (1..7 digits) -> ERR, no write.
- ERR/DONE: in_ready=0, im_we=0; state persists until start or reset.
- start during LOAD is ignored.
- Reset mid-load: immediate return to IDLE. IM contents already written are left as is.

Optional Feature:
- HEX_ADDR_DIRECTIVE_EN defined: '@' at digit_cnt==0 enters address mode. The following 1..8 hex digits, terminated by whitespace or in_last, set the next write address (low ADDR_W bits). word_count is unchanged.
  - '@' with zero digits, or more than 8 digits -> ERR.
  - A directive value >= 2^ADDR_W -> ERR.
- HEX_ADDR_DIRECTIVE_EN undefined: '@' is an illegal character -> ERR.

Decomposition:
- Shared package holds:
  - State encoding constants.
  - ASCII constants for space, tab, LF, CR and '@'.
  - The default IM address width.
- One natural sub-module: hex_char_decode (combinational). Maps in_char to {is_hex, is_space, is_at, nibble[3:0]}.

Test Plan:
- "00000000\n3c011234\n" + in_last on final LF -> writes 0x00000000 @0 and 0x3c011234 @1; word_count=2; done=1; err=0.
- "DEADbeef" with in_last on final 'f' -> one write of 0xdeadbeef @0, im_we exactly one cycle after the 'f' handshake; done=1.
- "1234 5678" -> err=1 on the space; no im_we ever; in_ready=0 afterwards.
- ADDR_W=2, five words streamed -> four writes at addresses 0..3; fifth completes -> err=1, word_count=4.
- Assert reset after 3 words, release, then start and stream "cafebabe" + in_last -> write 0xcafebabe @BASE_ADDR; word_count=1.
- With HEX_ADDR_DIRECTIVE_EN: "@10 00000001" -> write 0x00000001 @0x10. Without the macro: err=1 on '@'.

Source files
------------

// File: rtl/imem_hex_loader_pkg.sv
// Shared definitions for the instruction-memory hex loader.
//   - loader state encoding
//   - ASCII codes of the separator characters and the address-directive '@'
//   - default instruction-memory word-address width
package imem_hex_loader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2,
    ST_ERR  = 2'd3
  } state_e;

  localparam logic [7:0] ASCII_SP  = 8'h20;
  localparam logic [7:0] ASCII_TAB = 8'h09;
  localparam logic [7:0] ASCII_LF  = 8'h0A;
  localparam logic [7:0] ASCII_CR  = 8'h0D;
  localparam logic [7:0] ASCII_AT  = 8'h40;

  localparam int IM_ADDR_W_DEFAULT = 10;

endpackage

// File: rtl/imem_hex_loader_decode.sv
// Combinational ASCII character classifier for the hex loader.
// Ports:
//   char_i     : ASCII character
//   is_hex_o   : 0-9, A-F or a-f
//   is_space_o : space, tab, LF or CR
//   is_at_o    : '@'
//   nibble_o   : value of the hex digit (0 when not a hex digit)
module hex_char_decode
  import imem_hex_loader_pkg::*;
(
  input  logic [7:0] char_i,
  output logic       is_hex_o,
  output logic       is_space_o,
  output logic       is_at_o,
  output logic [3:0] nibble_o
);

  always_comb begin
    is_hex_o = 1'b0;
    nibble_o = 4'h0;
    if (char_i >= 8'h30 && char_i <= 8'h39) begin
      is_hex_o = 1'b1;
      nibble_o = char_i[3:0];
    end else if ((char_i >= 8'h41 && char_i <= 8'h46) ||
                 (char_i >= 8'h61 && char_i <= 8'h66)) begin
      // 'A'/'a' have low nibble 1, so adding 9 lands on 10.
      is_hex_o = 1'b1;
      nibble_o = char_i[3:0] + 4'd9;
    end
  end

  assign is_space_o = (char_i == ASCII_SP) || (char_i == ASCII_TAB) ||
                      (char_i == ASCII_LF) || (char_i == ASCII_CR);
  assign is_at_o    = (char_i == ASCII_AT);

endmodule

// File: rtl/imem_hex_loader.sv
// Instruction-memory hex loader: parses ASCII hex text (8 digits per 32-bit
// word, whitespace separated) and writes each word to consecutive IM word
// addresses starting at BASE_ADDR.
// Optional build macro HEX_ADDR_DIRECTIVE_EN: '@<hex>' sets the next write
// address; without it '@' is an illegal character.
// Ports:
//   clk, reset (async, active-low)
//   start                       : begin a load from IDLE/DONE/ERR
//   in_valid/in_ready/in_char/in_last : character stream handshake
//   im_we/im_addr/im_wdata      : IM write port, one strobe per word
//   busy/done/err               : LOAD / DONE / ERR state flags
//   word_count                  : words written in the current or last load
module imem_hex_loader
  import imem_hex_loader_pkg::*;
#(
  parameter int ADDR_W    = IM_ADDR_W_DEFAULT,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [7:0]        in_char,
  input  logic              in_last,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [31:0]       im_wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   word_count
);

  localparam logic [ADDR_W:0]   BASE_EXT  = (ADDR_W+1)'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] BASE_IM   = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W:0]   WCNT_FULL = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]   ONE_EXT   = (ADDR_W+1)'(1);

  state_e            state_q, state_d;
  logic [ADDR_W:0]   addr_q, addr_d;     // extra MSB flags "past the top"
  logic [3:0]        cnt_q, cnt_d;
  logic [31:0]       shift_q, shift_d;
  logic [ADDR_W:0]   wcnt_q, wcnt_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              amode_q, amode_d;   // collecting an '@' address

  logic              is_hex, is_space, is_at;
  logic [3:0]        nibble;
  logic [31:0]       shift_nx;
  logic              fail;

  hex_char_decode u_decode (
    .char_i     (in_char),
    .is_hex_o   (is_hex),
    .is_space_o (is_space),
    .is_at_o    (is_at),
    .nibble_o   (nibble)
  );

`ifdef HEX_ADDR_DIRECTIVE_EN
  logic term;

  function automatic logic addr_fits(input logic [31:0] v);
    return (v >> ADDR_W) == 32'd0;
  endfunction
`endif

  assign shift_nx = {shift_q[27:0], nibble};

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    wcnt_d  = wcnt_q;
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    amode_d = amode_q;
    fail    = 1'b0;
`ifdef HEX_ADDR_DIRECTIVE_EN
    term    = 1'b0;
`endif
    case (state_q)
      ST_LOAD: begin
        if (in_valid) begin
`ifdef HEX_ADDR_DIRECTIVE_EN
          if (amode_q) begin
            if (is_hex) begin
              if (cnt_q == 4'd8) begin
                fail = 1'b1;
              end else begin
                shift_d = shift_nx;
                cnt_d   = cnt_q + 4'd1;
              end
            end else if (is_space) begin
              term = 1'b1;
            end else begin
              fail = 1'b1;
            end
            // in_last also terminates the directive, after its own digit.
            if (!fail && (term || in_last)) begin
              if (cnt_d == 4'd0 || !addr_fits(shift_d)) begin
                fail = 1'b1;
              end else begin
                addr_d  = {1'b0, shift_d[ADDR_W-1:0]};
                amode_d = 1'b0;
                cnt_d   = 4'd0;
              end
            end
          end else
`endif
          if (is_hex) begin
            if (cnt_q == 4'd7) begin
              if (wcnt_q == WCNT_FULL || addr_q[ADDR_W]) begin
                fail = 1'b1;
              end else begin
                we_d    = 1'b1;
                waddr_d = addr_q[ADDR_W-1:0];
                wdata_d = shift_nx;
                addr_d  = addr_q + ONE_EXT;
                wcnt_d  = wcnt_q + ONE_EXT;
                shift_d = shift_nx;
                cnt_d   = 4'd0;
              end
            end else begin
              shift_d = shift_nx;
              cnt_d   = cnt_q + 4'd1;
            end
          end else if (is_space) begin
            // A completed word already cleared cnt, so 0 covers the 8 case.
            if (cnt_q != 4'd0) fail = 1'b1;
          end
`ifdef HEX_ADDR_DIRECTIVE_EN
          else if (is_at && cnt_q == 4'd0) begin
            amode_d = 1'b1;
            shift_d = 32'd0;
          end
`else
          else if (is_at) begin
            fail = 1'b1;
          end
`endif
          else begin
            fail = 1'b1;
          end

          if (fail) begin
            state_d = ST_ERR;
          end else if (in_last) begin
            state_d = (cnt_d == 4'd0 && !amode_d) ? ST_DONE : ST_ERR;
          end
        end
      end
      default: begin
        if (start) begin
          state_d = ST_LOAD;
          addr_d  = BASE_EXT;
          cnt_d   = 4'd0;
          shift_d = 32'd0;
          wcnt_d  = '0;
          amode_d = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      addr_q  <= BASE_EXT;
      cnt_q   <= 4'd0;
      shift_q <= 32'd0;
      wcnt_q  <= '0;
      we_q    <= 1'b0;
      waddr_q <= BASE_IM;
      wdata_q <= 32'd0;
      amode_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      wcnt_q  <= wcnt_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      amode_q <= amode_d;
    end
  end

  assign in_ready   = (state_q == ST_LOAD);
  assign busy       = (state_q == ST_LOAD);
  assign done       = (state_q == ST_DONE);
  assign err        = (state_q == ST_ERR);
  assign im_we      = we_q;
  assign im_addr    = waddr_q;
  assign im_wdata   = wdata_q;
  assign word_count = wcnt_q;

endmodule
